// File: rtl/cache_line_addr_gen.sv
// cache_line_addr_gen: rebuilds a cache line's full address from its tag and
// set index, then emits one bus-beat address per handshake for the whole line.
// The burst starts at the beat holding the critical word and wraps within the
// line.
//
// Ports:
//   i_clk, i_rst_n  clock and synchronous active-low reset
//   i_req_*         line request: tag, set index, critical-word byte offset
//   o_req_ready     request accepted when high together with i_req_valid
//   i_abort         drops the current burst; also blocks acceptance in IDLE
//   o_addr_*        beat address stream (valid/ready handshake, last flag)
//   o_busy          a burst is in progress
module cache_line_addr_gen #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BLOCK_SIZE  = 128,
    parameter int OFFSET_BITS = 7,
    parameter int INDEX_BITS  = 4,
    parameter int TAG_BITS    = 21,
    parameter int BEAT_BYTES  = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [TAG_BITS-1:0]    i_req_tag,
    input  logic [INDEX_BITS-1:0]  i_req_index,
    input  logic [OFFSET_BITS-1:0] i_req_offset,
    input  logic                   i_abort,
    output logic                   o_addr_valid,
    input  logic                   i_addr_ready,
    output logic [ADDR_WIDTH-1:0]  o_addr_out,
    output logic                   o_addr_last,
    output logic                   o_busy
);
    localparam int BEATS     = BLOCK_SIZE / BEAT_BYTES;
    localparam int BYTE_BITS = $clog2(BEAT_BYTES);
    localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [TAG_BITS-1:0]    r_tag;
    logic [INDEX_BITS-1:0]  r_index;
    logic [BEAT_BITS-1:0]   r_beat;
    logic [BEAT_BITS-1:0]   r_count;
    logic                   w_last;
    logic                   w_accept;
    logic                   w_hs;
    logic [OFFSET_BITS-1:0] w_offset;

    // r_count tracks beats already handed off, so it reaches BEATS-1 exactly
    // on the final beat regardless of where the wrap started.
    assign w_last   = (r_state == BURST) && (r_count == BEAT_BITS'(BEATS - 1));
    assign w_accept = i_req_valid && o_req_ready;
    assign w_hs     = o_addr_valid && i_addr_ready;
    assign w_offset = OFFSET_BITS'(r_beat) << BYTE_BITS;
    assign o_addr_out = {r_tag, r_index, w_offset};

    always_comb begin
        w_next       = r_state;
        o_req_ready  = 1'b0;
        o_addr_valid = 1'b0;
        o_busy       = 1'b0;
        o_addr_last  = 1'b0;
        if (r_state == IDLE) begin
            o_req_ready = !i_abort;
            if (i_req_valid && !i_abort) w_next = BURST;
        end else begin
            o_addr_valid = 1'b1;
            o_busy       = 1'b1;
            o_addr_last  = w_last;
            if (i_abort || (i_addr_ready && w_last)) w_next = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_tag   <= '0;
            r_index <= '0;
            r_beat  <= '0;
            r_count <= '0;
        end else if (w_accept) begin
            r_tag   <= i_req_tag;
            r_index <= i_req_index;
            // Byte bits below the beat width are dropped: start aligns down.
            r_beat  <= BEAT_BITS'(i_req_offset >> BYTE_BITS);
            r_count <= '0;
        end else if (w_hs) begin
            // BEATS is a power of two, so natural rollover wraps within the line.
            r_beat  <= r_beat + 1'b1;
            r_count <= r_count + 1'b1;
        end
    end
endmodule
